ext_unit_pipe: RTL

- Parametrised, pipelined successor to the single-cycle immediate extender.
- Supports immediate extension (zero, sign, lui, branch-offset) and load-data lane extraction/extension (lb, lbu, lh, lhu).
- Output is registered through PIPE_DEPTH stages, with stall/flush control matching the pipeline registers.
- Sits between decode/MEM and the stage consumers; a valid bit accompanies each result.

---
 rtl/ext_unit_pipe.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ext_unit_pipe.sv
//------------------------------------------------------------------------------
// ext_unit_pipe: pipelined immediate / load-lane extender. Optional macro
// EXT_ALIGN_CHK_EN adds a misalign output.                       Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ext_unit_pipe #(
  parameter int IN_W       = 16,
  parameter int OUT_W      = 32,
  parameter int PIPE_DEPTH = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2:0]         op,
  input  logic [IN_W-1:0]    imm,
  input  logic [OUT_W-1:0]   data,
  input  logic [1:0]         byte_off,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data
`ifdef EXT_ALIGN_CHK_EN
  ,
  output logic               misalign
`endif
);

  localparam logic [2:0] OP_ZERO = 3'd0;
  localparam logic [2:0] OP_SIGN = 3'd1;
  localparam logic [2:0] OP_LUI  = 3'd2;
  localparam logic [2:0] OP_SHL2 = 3'd3;
  localparam logic [2:0] OP_LB   = 3'd4;
  localparam logic [2:0] OP_LBU  = 3'd5;
  localparam logic [2:0] OP_LH   = 3'd6;
  localparam logic [2:0] OP_LHU  = 3'd7;

  generate
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 3) begin : g_bad_depth
      $error("ext_unit_pipe: PIPE_DEPTH must be in 1..3");
    end
    if (OUT_W < 32) begin : g_bad_out_w
      $error("ext_unit_pipe: OUT_W must be >= 32");
    end
    if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_in_w
      $error("ext_unit_pipe: IN_W must be in 1..OUT_W");
    end
  endgenerate

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] lui;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [OUT_W-1:0] ext_result;

  always_comb begin
    sext = {OUT_W{imm[IN_W-1]}};
    sext[IN_W-1:0] = imm;
    zext = '0;
    zext[IN_W-1:0] = imm;
    lui = '0;
    lui[OUT_W-1 -: IN_W] = imm;

    case (byte_off)
      2'd0:    ld_byte = data[7:0];
      2'd1:    ld_byte = data[15:8];
      2'd2:    ld_byte = data[23:16];
      default: ld_byte = data[31:24];
    endcase
    ld_half = byte_off[1] ? data[31:16] : data[15:0];

    ext_result = '0;
    case (op)
      OP_ZERO: ext_result = zext;
      OP_SIGN: ext_result = sext;
      OP_LUI:  ext_result = lui;
      OP_SHL2: ext_result = sext << 2;
      OP_LB: begin
        ext_result = {OUT_W{ld_byte[7]}};
        ext_result[7:0] = ld_byte;
      end
      OP_LBU:  ext_result[7:0] = ld_byte;
      OP_LH: begin
        ext_result = {OUT_W{ld_half[15]}};
        ext_result[15:0] = ld_half;
      end
      OP_LHU:  ext_result[15:0] = ld_half;
      default: ext_result = '0;
    endcase
  end

  logic [PIPE_DEPTH-1:0] vld;
  logic [OUT_W-1:0]      dat [PIPE_DEPTH];
`ifdef EXT_ALIGN_CHK_EN
  logic [PIPE_DEPTH-1:0] mis;
  logic                  ext_mis;

  // Flag only real entries so bubbles never report a misalignment.
  assign ext_mis = in_valid && (op == OP_LH || op == OP_LHU) && byte_off[0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) dat[k] <= '0;
`ifdef EXT_ALIGN_CHK_EN
      mis <= '0;
`endif
    end else if (flush) begin
      // Data registers keep their contents; only the valid bits are killed.
      vld <= '0;
`ifdef EXT_ALIGN_CHK_EN
      mis <= '0;
`endif
    end else if (!stall) begin
      for (int k = PIPE_DEPTH-1; k > 0; k--) begin
        vld[k] <= vld[k-1];
        dat[k] <= dat[k-1];
`ifdef EXT_ALIGN_CHK_EN
        mis[k] <= mis[k-1];
`endif
      end
      vld[0] <= in_valid;
      dat[0] <= ext_result;
`ifdef EXT_ALIGN_CHK_EN
      mis[0] <= ext_mis;
`endif
    end
  end

  assign out_valid = vld[PIPE_DEPTH-1];
  assign out_data  = dat[PIPE_DEPTH-1];
`ifdef EXT_ALIGN_CHK_EN
  assign misalign  = mis[PIPE_DEPTH-1];
`endif

endmodule

`default_nettype wire
